// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit types, output port codes, one-hot request bits, routing orders.
package noc_pkg;

   localparam logic [1:0] FlitBody     = 2'b00;
   localparam logic [1:0] FlitTail     = 2'b01;
   localparam logic [1:0] FlitHeader   = 2'b10;
   localparam logic [1:0] FlitHeadTail = 2'b11;

   localparam logic [3:0] PortL = 4'd1;
   localparam logic [3:0] PortE = 4'd2;
   localparam logic [3:0] PortN = 4'd3;
   localparam logic [3:0] PortW = 4'd4;
   localparam logic [3:0] PortS = 4'd5;

   localparam int unsigned BitL = 0;
   localparam int unsigned BitE = 1;
   localparam int unsigned BitN = 2;
   localparam int unsigned BitW = 3;
   localparam int unsigned BitS = 4;

   localparam int unsigned RouteXy = 0;
   localparam int unsigned RouteYx = 1;

   function automatic logic [4:0] port_onehot(input logic [3:0] port);
      logic [4:0] req;
      req = '0;
      unique case (port)
         PortL:   req[BitL] = 1'b1;
         PortE:   req[BitE] = 1'b1;
         PortN:   req[BitN] = 1'b1;
         PortW:   req[BitW] = 1'b1;
         PortS:   req[BitS] = 1'b1;
         default: req = '0;
      endcase
      return req;
   endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Combinational dimension-ordered route computation for one mesh node.
module xy_route_calc
   import noc_pkg::*;
#(
   parameter int unsigned X_NODE_NUM = 4,
   parameter int unsigned Y_NODE_NUM = 4,
   parameter int unsigned X_ADDR     = 1,
   parameter int unsigned Y_ADDR     = 2,
   parameter int unsigned ROUTE_MODE = RouteXy,
   parameter int unsigned X_W        = (X_NODE_NUM > 1) ? $clog2(X_NODE_NUM) : 1,
   parameter int unsigned Y_W        = (Y_NODE_NUM > 1) ? $clog2(Y_NODE_NUM) : 1
) (
   input  logic [X_W-1:0] dest_x,
   input  logic [Y_W-1:0] dest_y,
   output logic [3:0]     port,
   output logic           addr_ok
);

   localparam logic signed [X_W:0] XA = (X_W+1)'(X_ADDR);
   localparam logic signed [Y_W:0] YA = (Y_W+1)'(Y_ADDR);

   logic signed [X_W:0] dx;
   logic signed [Y_W:0] dy;
   logic                dx_neg, dx_pos, dy_neg, dy_pos;

   assign dx = $signed({1'b0, dest_x}) - XA;
   assign dy = $signed({1'b0, dest_y}) - YA;

   assign dx_neg = dx[X_W];
   assign dy_neg = dy[Y_W];
   assign dx_pos = !dx_neg && (dx != '0);
   assign dy_pos = !dy_neg && (dy != '0);

   assign addr_ok = (32'(dest_x) < X_NODE_NUM) && (32'(dest_y) < Y_NODE_NUM);

   always_comb begin
      port = PortL;
      if (ROUTE_MODE == RouteYx) begin
         if (dy_pos)      port = PortS;
         else if (dy_neg) port = PortN;
         else if (dx_pos) port = PortE;
         else if (dx_neg) port = PortW;
      end else begin
         if (dx_pos)      port = PortE;
         else if (dx_neg) port = PortW;
         else if (dy_pos) port = PortS;
         else if (dy_neg) port = PortN;
      end
   end

endmodule

// File: rtl/xy_route_stage.sv
// One-cycle wormhole route stage: computes the route on headers and locks it for the packet.
module xy_route_stage
   import noc_pkg::*;
#(
   parameter int unsigned X_NODE_NUM = 4,
   parameter int unsigned Y_NODE_NUM = 4,
   parameter int unsigned X_ADDR     = 1,
   parameter int unsigned Y_ADDR     = 2,
   parameter int unsigned FLIT_W     = 8,
   parameter int unsigned ROUTE_MODE = RouteXy
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLIT_W-1:0] in_flit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [FLIT_W-1:0] out_flit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        port_num,
   output logic [4:0]        port_req,
   output logic              err
);

   localparam int unsigned X_W = (X_NODE_NUM > 1) ? $clog2(X_NODE_NUM) : 1;
   localparam int unsigned Y_W = (Y_NODE_NUM > 1) ? $clog2(Y_NODE_NUM) : 1;

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e            state_q;
   logic [3:0]        route_q;
   logic [FLIT_W-1:0] out_flit_q;
   logic              out_valid_q;
   logic [3:0]        port_num_q;
   logic [4:0]        port_req_q;
   logic              err_q;

   logic [1:0] ftype;
   logic       is_head, is_tail, xfer;
   logic [3:0] calc_port;
   logic       addr_ok;

   xy_route_calc #(
      .X_NODE_NUM (X_NODE_NUM),
      .Y_NODE_NUM (Y_NODE_NUM),
      .X_ADDR     (X_ADDR),
      .Y_ADDR     (Y_ADDR),
      .ROUTE_MODE (ROUTE_MODE),
      .X_W        (X_W),
      .Y_W        (Y_W)
   ) u_calc (
      .dest_x  (in_flit[X_W-1:0]),
      .dest_y  (in_flit[X_W+Y_W-1:X_W]),
      .port    (calc_port),
      .addr_ok (addr_ok)
   );

   assign ftype   = in_flit[FLIT_W-1:FLIT_W-2];
   assign is_head = (ftype == FlitHeader) || (ftype == FlitHeadTail);
   assign is_tail = (ftype == FlitTail) || (ftype == FlitHeadTail);

   assign in_ready = !out_valid_q || out_ready;
   assign xfer     = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         route_q     <= '0;
         out_flit_q  <= '0;
         out_valid_q <= 1'b0;
         port_num_q  <= '0;
         port_req_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         // Consumed output falls unless a new flit is emitted below.
         if (out_ready) begin
            out_valid_q <= 1'b0;
            port_req_q  <= '0;
         end
         if (xfer) begin
            if (is_head) begin
               if (state_q == StLocked) err_q <= 1'b1;
               if (!addr_ok) begin
                  err_q   <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  out_flit_q  <= in_flit;
                  out_valid_q <= 1'b1;
                  port_num_q  <= calc_port;
                  port_req_q  <= port_onehot(calc_port);
                  route_q     <= calc_port;
                  state_q     <= is_tail ? StIdle : StLocked;
               end
            end else if (state_q == StLocked) begin
               out_flit_q  <= in_flit;
               out_valid_q <= 1'b1;
               port_num_q  <= route_q;
               port_req_q  <= port_onehot(route_q);
               if (is_tail) state_q <= StIdle;
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign out_flit  = out_flit_q;
   assign out_valid = out_valid_q;
   assign port_num  = port_num_q;
   assign port_req  = port_req_q;
   assign err       = err_q;

endmodule

// File: tb/tb_xy_route_stage.sv
// Directed bench for xy_route_stage: XY instance plus a YX instance sharing the same stimulus.
module tb_xy_route_stage;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_flit;
   logic       in_valid;
   logic       out_ready;

   logic       in_ready, out_valid, err;
   logic [7:0] out_flit;
   logic [3:0] port_num;
   logic [4:0] port_req;

   logic       in_ready_yx, out_valid_yx, err_yx;
   logic [7:0] out_flit_yx;
   logic [3:0] port_num_yx;
   logic [4:0] port_req_yx;

   int unsigned n_vec;
   int unsigned n_miss;

   xy_route_stage #(.ROUTE_MODE(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_flit   (in_flit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .port_num  (port_num),
      .port_req  (port_req),
      .err       (err)
   );

   xy_route_stage #(.ROUTE_MODE(1)) dut_yx (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_flit   (in_flit),
      .in_valid  (in_valid),
      .in_ready  (in_ready_yx),
      .out_flit  (out_flit_yx),
      .out_valid (out_valid_yx),
      .out_ready (out_ready),
      .port_num  (port_num_yx),
      .port_req  (port_req_yx),
      .err       (err_yx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] mk(input logic [1:0] t, input logic [1:0] x,
                                     input logic [1:0] y, input logic [1:0] p);
      return {t, p, y, x};
   endfunction

   logic [7:0] f_a, f_b, f_c;

   initial begin
      n_vec     = 0;
      n_miss    = 0;
      rst_n     = 1'b0;
      in_flit   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_flit", 32'(out_flit), 0);
      check("rst_port_num", 32'(port_num), 0);
      check("rst_port_req", 32'(port_req), 0);
      check("rst_err", 32'(err), 0);
      #11;
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 1);

      // Packet to (3,2): E for header, body and tail
      step();
      f_a = mk(2'b10, 2'd3, 2'd2, 2'd1);
      in_flit = f_a; in_valid = 1'b1;
      step();
      check("hdr_valid", 32'(out_valid), 1);
      check("hdr_flit", 32'(out_flit), 32'(f_a));
      check("hdr_port", 32'(port_num), 2);
      check("hdr_req", 32'(port_req), 32'b00010);
      check("hdr_port_yx", 32'(port_num_yx), 2);
      in_flit = 8'b00_101010;
      step();
      check("body_flit", 32'(out_flit), 32'h2A);
      check("body_port", 32'(port_num), 2);
      in_flit = 8'b01_110011;
      step();
      check("tail_flit", 32'(out_flit), 32'h73);
      check("tail_req", 32'(port_req), 32'b00010);

      // Single-flit packet to self, then (3,0): XY gives E, YX gives N
      in_flit = mk(2'b11, 2'd1, 2'd2, 2'd0);
      step();
      check("ht_local_port", 32'(port_num), 1);
      check("ht_local_req", 32'(port_req), 32'b00001);
      check("ht_no_err", 32'(err), 0);
      in_flit = mk(2'b11, 2'd3, 2'd0, 2'd0);
      step();
      check("xy_port_e", 32'(port_num), 2);
      check("yx_port_n", 32'(port_num_yx), 3);
      check("yx_req_n", 32'(port_req_yx), 32'b00100);
      check("idle_no_err", 32'(err), 0);
      in_valid = 1'b0;
      step();
      check("idle_valid", 32'(out_valid), 0);
      check("idle_req", 32'(port_req), 0);

      // Backpressure: A to W held for 3 cycles, B to S waits
      f_a = mk(2'b11, 2'd0, 2'd2, 2'd2);
      f_b = mk(2'b11, 2'd1, 2'd3, 2'd3);
      out_ready = 1'b0;
      in_flit = f_a; in_valid = 1'b1;
      step();
      check("bp_a_port", 32'(port_num), 4);
      in_flit = f_b;
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_hold_flit", 32'(out_flit), 32'(f_a));
         check("bp_hold_req", 32'(port_req), 32'b01000);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 1);
      step();
      check("bp_b_flit", 32'(out_flit), 32'(f_b));
      check("bp_b_port", 32'(port_num), 5);
      in_valid = 1'b0;
      step();
      check("bp_no_dup", 32'(out_valid), 0);

      // Protocol errors: BODY in IDLE, then header re-route while locked
      in_flit = 8'b00_000000; in_valid = 1'b1;
      step();
      check("body_idle_drop", 32'(out_valid), 0);
      check("body_idle_err", 32'(err), 1);
      in_flit = mk(2'b10, 2'd2, 2'd2, 2'd0);
      step();
      check("lock_hdr_port", 32'(port_num), 2);
      in_flit = mk(2'b10, 2'd1, 2'd0, 2'd0);
      step();
      check("relock_port", 32'(port_num), 3);
      check("relock_err", 32'(err), 1);
      f_c = 8'b01_111111;
      in_flit = f_c;
      step();
      check("relock_tail_flit", 32'(out_flit), 32'(f_c));
      check("relock_tail_port", 32'(port_num), 3);
      // Dropped flit while output is consumed: out_valid must fall
      in_flit = 8'b00_010101;
      step();
      check("drop_fall_valid", 32'(out_valid), 0);
      check("drop_fall_req", 32'(port_req), 0);
      in_valid = 1'b0;

      // Reset mid-packet
      rst_n = 1'b0;
      #1;
      check("rst2_err", 32'(err), 0);
      rst_n = 1'b1;
      step();
      in_flit = mk(2'b10, 2'd3, 2'd2, 2'd0); in_valid = 1'b1;
      step();
      check("mid_hdr_valid", 32'(out_valid), 1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_flit", 32'(out_flit), 0);
      check("mid_rst_port", 32'(port_num), 0);
      check("mid_rst_req", 32'(port_req), 0);
      step();
      rst_n = 1'b1;
      #1;
      check("mid_rel_ready", 32'(in_ready), 1);
      in_flit = 8'b01_000000; in_valid = 1'b1;
      step();
      check("mid_tail_drop", 32'(out_valid), 0);
      check("mid_tail_err", 32'(err), 1);
      in_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
